// File: rtl/pred_rf_pkg.sv
// rtl/pred_rf_pkg.sv - shared constants and select helper for the predicate register file
package pred_rf_pkg;

    localparam int PW_DEF    = 4;
    localparam int DEPTH_DEF = 64;
    localparam int NIN_DEF   = 4;
    localparam int NOUT_DEF  = 4;

    localparam int CH_EDGE1  = 0;
    localparam int CH_EDGE3  = 1;
    localparam int CH_EDGE24 = 2;
    localparam int CH_BUS    = 3;

    localparam int SEL_MAX   = 32;

    // Callers zero-extend their select to SEL_MAX bits.
    function automatic logic is_onehot(input logic [SEL_MAX-1:0] v);
        return (v != '0) && ((v & (v - SEL_MAX'(1))) == '0);
    endfunction

endpackage

// File: rtl/pred_rf_gen_if.sv
// rtl/pred_rf_gen_if.sv - port bundle for pred_rf_gen (master drives, slave is the file)
interface pred_rf_gen_if
    import pred_rf_pkg::*;
#(
    parameter int PW    = PW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NIN   = NIN_DEF,
    parameter int NOUT  = NOUT_DEF
);
    localparam int AW = $clog2(DEPTH);

    logic [NIN*PW-1:0]  in_data;
    logic [NIN-1:0]     put_in_sel;
    logic [AW-1:0]      put_in_addr;
    logic               wb_en;
    logic [AW-1:0]      wb_addr;
    logic [PW-1:0]      wb_data;
    logic [NIN-1:0]     pe2fu_sel;
    logic [AW-1:0]      pred_addr;
    logic [PW-1:0]      pred_out;
    logic               pred_out_valid;
    logic               send_en;
    logic [AW-1:0]      send_addr;
    logic               send_consume;
    logic [NOUT-1:0]    out_mask;
    logic [NOUT*PW-1:0] out_data;
    logic [NOUT-1:0]    out_valid;
    logic [AW:0]        valid_count;
    logic               wr_conflict;

    modport master (
        output in_data, put_in_sel, put_in_addr, wb_en, wb_addr, wb_data,
               pe2fu_sel, pred_addr, send_en, send_addr, send_consume, out_mask,
        input  pred_out, pred_out_valid, out_data, out_valid, valid_count, wr_conflict
    );

    modport slave (
        input  in_data, put_in_sel, put_in_addr, wb_en, wb_addr, wb_data,
               pe2fu_sel, pred_addr, send_en, send_addr, send_consume, out_mask,
        output pred_out, pred_out_valid, out_data, out_valid, valid_count, wr_conflict
    );

endinterface

// File: rtl/pred_onehot_mux.sv
// rtl/pred_onehot_mux.sv - NIN-way one-hot-or-zero predicate mux with valid flag
module pred_onehot_mux
    import pred_rf_pkg::*;
#(
    parameter int PW  = PW_DEF,
    parameter int NIN = NIN_DEF
) (
    input  logic [NIN-1:0]    sel,
    input  logic [NIN*PW-1:0] data,
    output logic [PW-1:0]     out,
    output logic              valid
);

    always_comb begin
        valid = is_onehot(SEL_MAX'(sel));
        out   = '0;
        for (int i = 0; i < NIN; i++) begin
            if (valid && sel[i]) begin
                out = data[i*PW +: PW];
            end
        end
    end

endmodule

// File: rtl/pred_rf_gen.sv
// rtl/pred_rf_gen.sv - parametrised predicate register file; PRED_RF_BYPASS_EN adds write-to-read forwarding
module pred_rf_gen
    import pred_rf_pkg::*;
#(
    parameter int PW    = PW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NIN   = NIN_DEF,
    parameter int NOUT  = NOUT_DEF
) (
    input logic        CLK,
    input logic        RST,
    pred_rf_gen_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_n;

    logic [PW-1:0] cap_data;
    logic          cap_en;
    logic [PW-1:0] byp_data;
    logic          byp_ok;
    logic          wb_hit_cap;
    logic          cons;
    logic          inc_cap;
    logic          inc_wb;
    logic          dec;
    logic [PW-1:0] rd_data;
    logic          rd_vld;
    logic [PW-1:0] src_data;
    logic          src_vld;

    pred_onehot_mux #(.PW(PW), .NIN(NIN)) u_cap_mux (
        .sel   (bus.put_in_sel),
        .data  (bus.in_data),
        .out   (cap_data),
        .valid (cap_en)
    );

    pred_onehot_mux #(.PW(PW), .NIN(NIN)) u_fu_mux (
        .sel   (bus.pe2fu_sel),
        .data  (bus.in_data),
        .out   (byp_data),
        .valid (byp_ok)
    );

    always_comb begin
        rd_data  = vld[bus.pred_addr] ? mem[bus.pred_addr] : '0;
        rd_vld   = vld[bus.pred_addr];
        src_data = mem[bus.send_addr];
        src_vld  = vld[bus.send_addr];
`ifdef PRED_RF_BYPASS_EN
        // Write-back is checked last so it overrides a same-address capture.
        if (cap_en && bus.put_in_addr == bus.pred_addr) begin
            rd_data = cap_data;
            rd_vld  = 1'b1;
        end
        if (bus.wb_en && bus.wb_addr == bus.pred_addr) begin
            rd_data = bus.wb_data;
            rd_vld  = 1'b1;
        end
        if (cap_en && bus.put_in_addr == bus.send_addr) begin
            src_data = cap_data;
            src_vld  = 1'b1;
        end
        if (bus.wb_en && bus.wb_addr == bus.send_addr) begin
            src_data = bus.wb_data;
            src_vld  = 1'b1;
        end
`endif
        if (byp_ok) begin
            bus.pred_out       = byp_data;
            bus.pred_out_valid = 1'b1;
        end else if (bus.pe2fu_sel == '0) begin
            bus.pred_out       = rd_data;
            bus.pred_out_valid = rd_vld;
        end else begin
            bus.pred_out       = '0;
            bus.pred_out_valid = 1'b0;
        end
    end

    always_comb begin
        wb_hit_cap = bus.wb_en && (bus.wb_addr == bus.put_in_addr);
        cons       = bus.send_en && bus.send_consume;
        inc_cap    = cap_en && !vld[bus.put_in_addr] && !wb_hit_cap;
        inc_wb     = bus.wb_en && !vld[bus.wb_addr];
        // A consumed entry that is rewritten in the same cycle stays valid.
        dec        = cons && vld[bus.send_addr]
                     && !(cap_en && bus.put_in_addr == bus.send_addr)
                     && !(bus.wb_en && bus.wb_addr == bus.send_addr);
        cnt_n      = cnt + (AW+1)'(inc_cap) + (AW+1)'(inc_wb) - (AW+1)'(dec);
    end

    always_ff @(posedge CLK) begin
        if (bus.wb_en) begin
            mem[bus.wb_addr] <= bus.wb_data;
        end
        if (cap_en && !wb_hit_cap) begin
            mem[bus.put_in_addr] <= cap_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld             <= '0;
            cnt             <= '0;
            bus.out_data    <= '0;
            bus.out_valid   <= '0;
            bus.wr_conflict <= 1'b0;
        end else begin
            assert (cnt_n <= (AW+1)'(DEPTH));
            if (cons) begin
                vld[bus.send_addr] <= 1'b0;
            end
            if (cap_en) begin
                vld[bus.put_in_addr] <= 1'b1;
            end
            if (bus.wb_en) begin
                vld[bus.wb_addr] <= 1'b1;
            end
            cnt <= cnt_n;
            if (cap_en && wb_hit_cap) begin
                bus.wr_conflict <= 1'b1;
            end
            for (int j = 0; j < NOUT; j++) begin
                bus.out_data[j*PW +: PW] <= (bus.send_en && bus.out_mask[j]) ? src_data : '0;
                bus.out_valid[j]         <= bus.send_en && bus.out_mask[j] && src_vld;
            end
        end
    end

    assign bus.valid_count = cnt;

endmodule

// File: tb/tb_pred_rf_gen.sv
// tb/tb_pred_rf_gen.sv - randomized self-checking bench for pred_rf_gen against an array model
module tb_pred_rf_gen;
    import pred_rf_pkg::*;

    localparam int PW    = 4;
    localparam int DEPTH = 64;
    localparam int NIN   = 4;
    localparam int NOUT  = 4;
    localparam int AW    = $clog2(DEPTH);

    logic CLK = 1'b0;
    logic RST;

    pred_rf_gen_if #(.PW(PW), .DEPTH(DEPTH), .NIN(NIN), .NOUT(NOUT)) bus ();

    pred_rf_gen #(.PW(PW), .DEPTH(DEPTH), .NIN(NIN), .NOUT(NOUT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    logic [PW-1:0] m_mem   [DEPTH];
    bit            m_vld   [DEPTH];
    bit            m_known [DEPTH];
    bit            m_conf;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] chan(input logic [NIN*PW-1:0] d, input int i);
        return d[i*PW +: PW];
    endfunction

    function automatic int sel_index(input logic [NIN-1:0] s);
        for (int i = 0; i < NIN; i++) if (s[i]) return i;
        return 0;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_vld[i]);
        return c;
    endfunction

    task automatic idle();
        bus.in_data      = '0;
        bus.put_in_sel   = '0;
        bus.put_in_addr  = '0;
        bus.wb_en        = 1'b0;
        bus.wb_addr      = '0;
        bus.wb_data      = '0;
        bus.pe2fu_sel    = '0;
        bus.pred_addr    = '0;
        bus.send_en      = 1'b0;
        bus.send_addr    = '0;
        bus.send_consume = 1'b0;
        bus.out_mask     = '0;
    endtask

    // One clock: check the combinational read, advance the model, check registered state.
    task automatic step();
        logic [PW-1:0] e_rd, cap_d, src_d;
        bit e_rv, cap_ok, src_v, src_k, wr_cap, wr_wb;
        int pa, sa, ca, wa;
        logic [NOUT-1:0] mask;
        bit send, rst_now;
        #2;
        cap_ok = ($countones(bus.put_in_sel) == 1);
        cap_d  = chan(bus.in_data, sel_index(bus.put_in_sel));
        pa = int'(bus.pred_addr); sa = int'(bus.send_addr);
        ca = int'(bus.put_in_addr); wa = int'(bus.wb_addr);
        wr_wb  = bus.wb_en;
        wr_cap = cap_ok && !(wr_wb && wa == ca);
        if ($countones(bus.pe2fu_sel) == 1) begin
            e_rd = chan(bus.in_data, sel_index(bus.pe2fu_sel)); e_rv = 1;
        end else if (bus.pe2fu_sel == '0) begin
            e_rd = m_vld[pa] ? m_mem[pa] : '0; e_rv = m_vld[pa];
`ifdef PRED_RF_BYPASS_EN
            if (wr_wb && wa == pa) begin e_rd = bus.wb_data; e_rv = 1; end
            else if (cap_ok && ca == pa) begin e_rd = cap_d; e_rv = 1; end
`endif
        end else begin
            e_rd = '0; e_rv = 0;
        end
        check("pred_out", 32'(bus.pred_out), 32'(e_rd));
        check("pred_out_valid", 32'(bus.pred_out_valid), 32'(e_rv));

        src_d = m_mem[sa]; src_v = m_vld[sa]; src_k = m_known[sa];
`ifdef PRED_RF_BYPASS_EN
        if (wr_wb && wa == sa) begin src_d = bus.wb_data; src_v = 1; src_k = 1; end
        else if (cap_ok && ca == sa) begin src_d = cap_d; src_v = 1; src_k = 1; end
`endif
        mask = bus.out_mask; send = bus.send_en; rst_now = RST;

        if (wr_cap) begin m_mem[ca] = cap_d; m_known[ca] = 1; end
        if (wr_wb)  begin m_mem[wa] = bus.wb_data; m_known[wa] = 1; end
        if (rst_now) begin
            for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
            m_conf = 0;
        end else begin
            if (send && bus.send_consume) m_vld[sa] = 0;
            if (cap_ok) m_vld[ca] = 1;
            if (wr_wb)  m_vld[wa] = 1;
            if (cap_ok && wr_wb && wa == ca) m_conf = 1;
        end

        @(posedge CLK);
        #1;
        check("valid_count", 32'(bus.valid_count), 32'(model_count()));
        check("wr_conflict", 32'(bus.wr_conflict), 32'(m_conf));
        for (int j = 0; j < NOUT; j++) begin
            bit live = !rst_now && send && mask[j];
            check($sformatf("out_valid[%0d]", j), 32'(bus.out_valid[j]), 32'(live && src_v));
            if (!live)
                check($sformatf("out_data[%0d]", j), 32'(bus.out_data[j*PW +: PW]), 32'(0));
            else if (src_k)
                check($sformatf("out_data[%0d]", j), 32'(bus.out_data[j*PW +: PW]), 32'(src_d));
        end
    endtask

    task automatic rand_sel(output logic [NIN-1:0] s);
        int r = $urandom_range(0, 7);
        if (r < 4)      s = NIN'(1) << $urandom_range(0, NIN-1);
        else if (r < 6) s = '0;
        else            s = NIN'($urandom);
    endtask

    initial begin
        logic [NIN-1:0] s;
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i] = 0; m_known[i] = 0; m_mem[i] = '0;
        end
        m_conf = 0;
        idle();
        RST = 1'b1;
        @(posedge CLK); #1;
        step();
        RST = 1'b0;
        check("reset_count", 32'(bus.valid_count), 32'(0));
        check("reset_out_valid", 32'(bus.out_valid), 32'(0));
        for (int a = 0; a < DEPTH; a++) begin
            bus.pred_addr = AW'(a);
            step();
        end

        idle();
        bus.in_data[CH_BUS*PW +: PW] = 4'hA;
        bus.put_in_sel  = 4'b1000;
        bus.put_in_addr = 6'd5;
        step();
        idle();
        bus.pred_addr = 6'd5;
        #1;
        check("cap5_data", 32'(bus.pred_out), 32'hA);
        check("cap5_count", 32'(bus.valid_count), 32'd1);
        step();

        idle();
        bus.in_data[CH_EDGE1*PW +: PW] = 4'h3;
        bus.put_in_sel  = 4'b0001;
        bus.put_in_addr = 6'd9;
        bus.wb_en = 1'b1; bus.wb_addr = 6'd9; bus.wb_data = 4'hC;
        step();
        idle();
        bus.pred_addr = 6'd9;
        #1;
        check("conflict_data", 32'(bus.pred_out), 32'hC);
        check("conflict_flag", 32'(bus.wr_conflict), 32'd1);
        check("conflict_count", 32'(bus.valid_count), 32'd2);

        idle();
        bus.send_en = 1'b1; bus.send_addr = 6'd5; bus.out_mask = 4'b0101; bus.send_consume = 1'b1;
        step();
        check("send_data", 32'(bus.out_data), 32'h0A0A);
        check("send_valid", 32'(bus.out_valid), 32'b0101);
        check("send_count", 32'(bus.valid_count), 32'd1);
        idle();
        step();
        check("send_hold", 32'(bus.out_valid), 32'd0);

        idle();
        bus.send_en = 1'b1; bus.send_addr = 6'd9; bus.send_consume = 1'b1; bus.out_mask = 4'b1111;
        bus.wb_en = 1'b1; bus.wb_addr = 6'd9; bus.wb_data = 4'h6;
        step();
        idle();
        bus.pred_addr = 6'd9;
        #1;
        check("consume_wb_data", 32'(bus.pred_out), 32'h6);
        check("consume_wb_count", 32'(bus.valid_count), 32'd1);

        idle();
        bus.in_data = 16'h5A3C;
        bus.pe2fu_sel = 4'b0011;
        #1;
        check("bad_sel_data", 32'(bus.pred_out), 32'd0);
        check("bad_sel_valid", 32'(bus.pred_out_valid), 32'd0);
        step();

        idle();
        bus.wb_en = 1'b1; bus.wb_addr = 6'd2; bus.wb_data = 4'h7; bus.pred_addr = 6'd2;
        #1;
`ifdef PRED_RF_BYPASS_EN
        check("bypass_data", 32'(bus.pred_out), 32'h7);
        check("bypass_valid", 32'(bus.pred_out_valid), 32'd1);
`else
        check("nobypass_data", 32'(bus.pred_out), 32'd0);
        check("nobypass_valid", 32'(bus.pred_out_valid), 32'd0);
`endif
        step();

        for (int n = 0; n < 600; n++) begin
            idle();
            bus.in_data = 16'($urandom);
            rand_sel(s); bus.put_in_sel = s;
            rand_sel(s); bus.pe2fu_sel = s;
            bus.put_in_addr  = AW'($urandom_range(0, 15));
            bus.wb_en        = ($urandom_range(0, 2) == 0);
            bus.wb_addr      = AW'($urandom_range(0, 15));
            bus.wb_data      = PW'($urandom);
            bus.pred_addr    = AW'($urandom_range(0, 15));
            bus.send_en      = ($urandom_range(0, 1) == 1);
            bus.send_addr    = AW'($urandom_range(0, 15));
            bus.send_consume = ($urandom_range(0, 1) == 1);
            bus.out_mask     = NOUT'($urandom);
            if ($urandom_range(0, 79) == 0) begin
                RST = 1'b1;
                bus.put_in_sel = '0;
                bus.wb_en = 1'b0;
                bus.send_en = 1'b1;
                bus.send_consume = 1'b1;
            end
            step();
            RST = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
